// File: rtl/mux_nx1_rr.sv
// N-input registered data selector with valid/ready on every channel and on the output.
// Define MUX_RR_EN to build round-robin mode and its pointer; otherwise mode is ignored (direct select only).
module mux_nx1_rr #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0] r_outData;
   logic [SELW-1:0]  r_outCh;
   logic             r_outValid;

   logic             w_load;
   logic             w_directHit;
   logic             w_chosen;
   logic [SELW-1:0]  w_ch;
   logic [WIDTH-1:0] w_selData;
   logic             w_rrMode;
   logic             w_rrFound;
   logic [SELW-1:0]  w_rrCh;

`ifdef MUX_RR_EN
   logic [SELW-1:0]  r_ptr;
   logic [N-1:0]     w_rot;
   logic [SELW-1:0]  w_rrOff;
   logic [SELW:0]    w_rrSum;
   logic [SELW:0]    w_ptrInc;
   logic [SELW-1:0]  w_ptrNext;

   assign w_rrMode = mode;

   // Rotate requests so bit 0 is the pointer position; the lowest set bit is the winner.
   always_comb begin
      w_rot     = N'({in_valid, in_valid} >> r_ptr);
      w_rrFound = 1'b0;
      w_rrOff   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_rrFound = 1'b1;
            w_rrOff   = SELW'(j);
         end
      end
      w_rrSum = {1'b0, r_ptr} + {1'b0, w_rrOff};
      if (w_rrSum >= (SELW+1)'(N))
         w_rrSum = w_rrSum - (SELW+1)'(N);
      w_rrCh    = w_rrSum[SELW-1:0];
      w_ptrInc  = {1'b0, w_rrCh} + (SELW+1)'(1);
      w_ptrNext = (w_ptrInc >= (SELW+1)'(N)) ? '0 : w_ptrInc[SELW-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_ptr <= '0;
      else if (w_load && w_rrMode && w_rrFound)
         r_ptr <= w_ptrNext;
   end
`else
   logic w_unusedMode;
   assign w_unusedMode = mode;
   assign w_rrMode     = 1'b0;
   assign w_rrFound    = 1'b0;
   assign w_rrCh       = '0;
`endif

   always_comb begin
      w_load      = !r_outValid || out_ready;
      w_directHit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (SELW'(i) == sel && in_valid[i])
            w_directHit = 1'b1;
      end
      if (w_rrMode) begin
         w_chosen = w_rrFound;
         w_ch     = w_rrCh;
      end else begin
         w_chosen = w_directHit;
         w_ch     = sel;
      end
      w_selData = '0;
      for (int i = 0; i < N; i++) begin
         if (SELW'(i) == w_ch)
            w_selData = in_data[i*WIDTH +: WIDTH];
      end
      for (int i = 0; i < N; i++)
         in_ready[i] = rst_n && w_chosen && w_load && (w_ch == SELW'(i));
   end

   // Empty loads clear valid but keep the last word and channel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outCh    <= '0;
      end else if (w_load) begin
         r_outValid <= w_chosen;
         if (w_chosen) begin
            r_outData <= w_selData;
            r_outCh   <= w_ch;
         end
      end
   end

   assign out_data  = r_outData;
   assign out_ch    = r_outCh;
   assign out_valid = r_outValid;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Scoreboard bench for mux_nx1_rr: N=4 instance with queued expectations, plus an N=3 instance for out-of-range select.
module tb_mux_nx1_rr;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [N-1:0]         inValid;
   logic [WIDTH-1:0]     chData [N];
   logic [N*WIDTH-1:0]   inData;
   logic [N-1:0]         inReady;
   logic [WIDTH-1:0]     outData;
   logic [SELW-1:0]      outCh;
   logic                 outValid;
   logic                 outReady;

   logic                 mode3;
   logic [SELW-1:0]      sel3;
   logic [2:0]           inValid3;
   logic [3*WIDTH-1:0]   inData3;
   logic [2:0]           inReady3;
   logic [WIDTH-1:0]     outData3;
   logic [SELW-1:0]      outCh3;
   logic                 outValid3;
   logic                 outReady3;

   int checks = 0;
   int errors = 0;
   logic [SELW+WIDTH-1:0] expQ [$];

   always #5 clk = ~clk;

   assign inData  = {chData[3], chData[2], chData[1], chData[0]};
   assign inData3 = {32'h0000_0302, 32'h0000_0301, 32'h0000_0300};

   mux_nx1_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(inValid), .in_data(inData), .in_ready(inReady),
      .out_data(outData), .out_ch(outCh), .out_valid(outValid), .out_ready(outReady)
   );

   mux_nx1_rr #(.WIDTH(WIDTH), .N(3), .SELW(SELW)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
      .in_valid(inValid3), .in_data(inData3), .in_ready(inReady3),
      .out_data(outData3), .out_ch(outCh3), .out_valid(outValid3), .out_ready(outReady3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, queue the word they should load, and check the grant before the edge.
   task automatic applyStimulus(input logic m, input logic [SELW-1:0] s, input logic [N-1:0] v,
                                input logic r, input logic [N-1:0] expGrant,
                                input logic doPush, input logic [SELW-1:0] pCh,
                                input logic [WIDTH-1:0] pData);
      mode     = m;
      sel      = s;
      inValid  = v;
      outReady = r;
      if (doPush)
         expQ.push_back({pCh, pData});
      @(negedge clk);
      check("in_ready", 64'(inReady), 64'(expGrant));
   endtask

   task automatic checkOutput(input logic expValid, input logic [WIDTH-1:0] expData,
                              input logic [SELW-1:0] expCh);
      check("out_valid", 64'(outValid), 64'(expValid));
      check("out_data", 64'(outData), 64'(expData));
      check("out_ch", 64'(outCh), 64'(expCh));
   endtask

   // Every accepted output word is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && outValid === 1'b1 && outReady === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word actual=%0h/%0h required=none", outCh, outData);
         end else begin
            logic [SELW+WIDTH-1:0] e;
            e = expQ.pop_front();
            check("sb_ch", 64'(outCh), 64'(e[SELW+WIDTH-1:WIDTH]));
            check("sb_data", 64'(outData), 64'(e[WIDTH-1:0]));
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      mode3     = 1'b0;
      sel3      = '0;
      inValid3  = '0;
      outReady3 = 1'b1;
      for (int i = 0; i < N; i++) chData[i] = '0;

      applyStimulus(0, 0, 4'hF, 1, 4'b0000, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 4'hF, 1, 4'b0000, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 4'hF, 1, 4'b0000, 0, 0, 0);
      checkOutput(0, 32'h0, 0);
      tick();
      rst_n = 1'b1;

      $display("[TB] direct select");
      chData[0] = 32'h0000_0000;
      chData[1] = 32'hFFFF_FFFF;
      applyStimulus(0, 1, 4'b0011, 1, 4'b0010, 1, 1, 32'hFFFF_FFFF);
      tick();
      applyStimulus(0, 0, 4'b0011, 1, 4'b0001, 1, 0, 32'h0000_0000);
      checkOutput(1, 32'hFFFF_FFFF, 1);
      tick();
      applyStimulus(0, 1, 4'b0011, 1, 4'b0010, 1, 1, 32'hFFFF_FFFF);
      checkOutput(1, 32'h0000_0000, 0);
      tick();
      applyStimulus(0, 2, 4'b0011, 1, 4'b0000, 0, 0, 0);
      checkOutput(1, 32'hFFFF_FFFF, 1);
      tick();
      applyStimulus(0, 2, 4'b0011, 1, 4'b0000, 0, 0, 0);
      checkOutput(0, 32'hFFFF_FFFF, 1);
      tick();

      $display("[TB] backpressure");
      chData[0] = 32'hA5A5_A5A5;
      applyStimulus(0, 0, 4'b0001, 1, 4'b0001, 1, 0, 32'hA5A5_A5A5);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 4'b0011, 0, 4'b0000, 0, 0, 0);
         checkOutput(1, 32'hA5A5_A5A5, 0);
         tick();
      end
      applyStimulus(0, 1, 4'b0011, 1, 4'b0010, 1, 1, 32'hFFFF_FFFF);
      checkOutput(1, 32'hA5A5_A5A5, 0);
      tick();
      applyStimulus(0, 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
      checkOutput(1, 32'hFFFF_FFFF, 1);
      tick();
      applyStimulus(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
      checkOutput(0, 32'hFFFF_FFFF, 1);
      tick();

      for (int i = 0; i < N; i++) chData[i] = 32'h100 + i;
`ifdef MUX_RR_EN
      $display("[TB] round-robin fairness");
      for (int k = 0; k < 5; k++)
      begin
         applyStimulus(1, 0, 4'hF, 1, 4'(1 << (k % 4)), 1, SELW'(k % 4), 32'h100 + (k % 4));
         tick();
      end
      applyStimulus(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
      tick();
      rst_n = 1'b0;
      applyStimulus(1, 0, 4'b1010, 1, 4'b0000, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      $display("[TB] round-robin skip");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 0, 4'b1010, 1, (k % 2 == 0) ? 4'b0010 : 4'b1000, 1,
                       (k % 2 == 0) ? 2'd1 : 2'd3, (k % 2 == 0) ? 32'h101 : 32'h103);
         tick();
      end
      applyStimulus(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
      tick();
`else
      $display("[TB] mode ignored without round-robin");
      applyStimulus(1, 2, 4'hF, 1, 4'b0100, 1, 2, 32'h102);
      tick();
      applyStimulus(1, 3, 4'b0000, 1, 4'b0000, 0, 0, 0);
      checkOutput(1, 32'h102, 2);
      tick();
`endif

      $display("[TB] out-of-range select on N=3");
      sel3     = 2'd2;
      inValid3 = 3'b111;
      @(negedge clk);
      check("n3_grant_ch2", 64'(inReady3), 64'(3'b100));
      tick();
      sel3 = 2'd3;
      @(negedge clk);
      check("n3_grant_oor", 64'(inReady3), 64'(3'b000));
      check("n3_valid", 64'(outValid3), 64'(1'b1));
      check("n3_data", 64'(outData3), 64'(32'h302));
      tick();
      @(negedge clk);
      check("n3_valid_fall", 64'(outValid3), 64'(1'b0));
      check("n3_ch_hold", 64'(outCh3), 64'(2'd2));
`ifndef MUX_RR_EN
      tick();
      mode3 = 1'b1;
      sel3  = 2'd1;
      @(negedge clk);
      check("n3_mode_direct", 64'(inReady3), 64'(3'b010));
      tick();
      @(negedge clk);
      check("n3_mode_ch", 64'(outCh3), 64'(2'd1));
`endif
      inValid3 = '0;
      tick();
      tick();
      check("queue_empty", 64'(expQ.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-input, W-bit registered data selector with a valid/ready handshake on every input and on the output. It replaces the combinational 32-bit 2:1 mux wherever several datapath sources compete for one registered destination, such as register-file write-back or bus source select. It selects a channel either directly from `sel` or by round-robin over requesting channels, and holds the selected word until the consumer takes it.

## Interface
Parameters:
- `WIDTH`, 32: data width per channel.
- `N`, 4: number of input channels, 2..16.
- `SELW`, 2: select/channel-index width; must satisfy 2^SELW >= N.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `mode`, input, 1: 0 = direct select, 1 = round-robin.
- `sel`, input, SELW: channel index used in direct mode.
- `in_valid`, input, N: per-channel request.
- `in_data`, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`, output, N: one-hot or zero; the grant to channel i.
- `out_data`, output, WIDTH: registered selected word.
- `out_ch`, output, SELW: index of the channel that supplied `out_data`.
- `out_valid`, output, 1: output register holds a word.
- `out_ready`, input, 1: consumer accepts the word.

## Operation
- Single output register (`out_data`, `out_ch`, `out_valid`).
- The load enable is `load = !out_valid || out_ready`.
- A channel c is *chosen* each cycle:
  - Direct mode: c = `sel`, only if `sel` < N and `in_valid[sel]`. `sel` >= N chooses nothing.
  - Round-robin mode: c is the first i with `in_valid[i]`, scanning ptr, ptr+1, … and wrapping modulo N.
- `in_ready[c] = load` when a channel is chosen; all other `in_ready` bits are 0.
  - `in_ready` is combinational from `in_valid`, `sel`, `mode`, the pointer and `out_ready`.
  - `in_ready` never depends on `in_valid` of the same channel except through the choice itself.
- Transfer on an input occurs when `in_valid[c] && in_ready[c]`. On the next edge:
  - `out_data` and `out_ch` load channel c.
  - `out_valid` becomes 1.
- When `load` is 1 and nothing is chosen, `out_valid` goes to 0 on the next edge. `out_data` and `out_ch` hold their previous values.
- Round-robin pointer `ptr` (SELW bits):
  - On a round-robin transfer from c, `ptr` becomes (c+1) mod N; wrap N-1 → 0.
  - `ptr` is unchanged by direct-mode transfers and by idle cycles.
- `mode` and `sel` may change on any cycle. The new value governs the next choice only; a word already in the output register is unaffected.
- Data is passed bit-exact; there is no arithmetic on data.

## Timing
- Reset (`rst_n`=0 at an edge) sets `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0. `in_ready`=0 while `rst_n` is low.
- Reset mid-transfer discards the held word. Inputs offered that cycle are not taken.
- Latency: input transfer at edge k produces `out_valid`=1 after edge k, i.e. 1 cycle.
- Throughput: one word per cycle while `out_ready`=1 continuously.
- Stall: with `out_valid`=1 and `out_ready`=0, all `in_ready` bits are 0 and the output is stable.
- Simultaneous drain and fill: `out_ready`=1 with a chosen channel replaces the word with no bubble.
- All N channels requesting in round-robin mode with `out_ready`=1 grants 0,1,…,N-1,0,… on consecutive cycles.

## Configuration
- `MUX_RR_EN` defined: round-robin mode and `ptr` are built as described above.
- `MUX_RR_EN` undefined:
  - The `mode` port remains but is ignored; the block behaves as direct select permanently.
  - `ptr` is not implemented.
  - The behaviour of `out_*` and `in_ready` is otherwise identical.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `in_valid`=4'hF. Required: `out_valid`=0, `out_data`=0, `out_ch`=0, `in_ready`=0.
- **Direct select, WIDTH=32, N=4:**
  - Stimulus: ch0=32'h0, ch1=32'hFFFFFFFF, `in_valid`=4'b0011, `out_ready`=1; toggle `sel` 1,0,1 each cycle.
  - Required: `out_data` = FFFFFFFF, 00000000, FFFFFFFF one cycle after each select; `out_ch` follows.
- **Round-robin fairness:**
  - Stimulus: `mode`=1, `in_valid`=4'hF, `out_ready`=1, ch i data = 32'h100+i.
  - Required: `out_ch` sequence is 0,1,2,3,0. The `in_ready` one-hot rotates identically.
- **Round-robin skip:**
  - Stimulus: `in_valid`=4'b1010 from reset.
  - Required: grant order is 1,3,1,3. `ptr` is 2,0,2,0 after each transfer.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 3 cycles while `out_valid`=1 with 32'hA5A5A5A5.
  - Required: output is stable and `in_ready`=0. On release, the next word loads on the same edge the held word drains.
- **Out-of-range select / config:**
  - Stimulus: N=3, `sel`=3, `in_valid`=3'b111.
  - Required: no grant and `out_valid` falls to 0. With `MUX_RR_EN` undefined, `mode`=1 behaves as direct.
